// File: rtl/solver_feeder.sv
// Host-side feeder for one solver: loads config and c limbs, pulses start, returns the iteration count.
// Define SOLVER_FEEDER_TIMEOUT_EN to add a watchdog with res_timeout/solver_abort ports.
module solver_feeder #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TIMEOUT_CYCLES  = 2**20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [15:0]                job_id,
  input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
  input  logic [15:0]                job_iter_lim,
  input  logic                       limb_valid,
  output logic                       limb_ready,
  input  logic [LIMB_BITS-1:0]       limb_re,
  input  logic [LIMB_BITS-1:0]       limb_im,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_ind,
  output logic [LIMB_BITS-1:0]       wr_data_re,
  output logic [LIMB_BITS-1:0]       wr_data_im,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iteration_count,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_id,
  output logic [15:0]                res_count
`ifdef SOLVER_FEEDER_TIMEOUT_EN
  ,
  output logic                       res_timeout,
  output logic                       solver_abort
`endif
);

  typedef enum logic [2:0] {IDLE, CFG, LIMBS, START, HOLD, RUN, RESULT} state_t;

  state_t                     state_q, state_d;
  logic                       job_ready_q, job_ready_d;
  logic                       limb_ready_q, limb_ready_d;
  logic [15:0]                job_id_q, job_id_d;
  logic [LIMB_INDEX_BITS-1:0] limb_cnt_q, limb_cnt_d;
  logic [15:0]                cap_count_q, cap_count_d;
  logic                       wr_en_q, wr_en_d;
  logic [LIMB_INDEX_BITS-1:0] wr_ind_q, wr_ind_d;
  logic [LIMB_BITS-1:0]       wr_data_re_q, wr_data_re_d;
  logic [LIMB_BITS-1:0]       wr_data_im_q, wr_data_im_d;
  logic                       cfg_en_q, cfg_en_d;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_q, num_limbs_d;
  logic [15:0]                iter_lim_q, iter_lim_d;
  logic                       start_q, start_d;
  logic                       res_valid_q, res_valid_d;
  logic [15:0]                res_id_q, res_id_d;
  logic [15:0]                res_count_q, res_count_d;

`ifdef SOLVER_FEEDER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] timer_q, timer_d;
  logic        cap_timeout_q, cap_timeout_d;
  logic        res_timeout_q, res_timeout_d;
  logic        abort_q, abort_d;
`endif

  always_comb begin
    state_d      = state_q;
    job_id_d     = job_id_q;
    limb_cnt_d   = limb_cnt_q;
    cap_count_d  = cap_count_q;
    wr_en_d      = 1'b0;
    wr_ind_d     = wr_ind_q;
    wr_data_re_d = wr_data_re_q;
    wr_data_im_d = wr_data_im_q;
    cfg_en_d     = 1'b0;
    num_limbs_d  = num_limbs_q;
    iter_lim_d   = iter_lim_q;
    start_d      = 1'b0;
    res_valid_d  = res_valid_q & ~res_ready;
    res_id_d     = res_id_q;
    res_count_d  = res_count_q;
`ifdef SOLVER_FEEDER_TIMEOUT_EN
    timer_d       = timer_q;
    cap_timeout_d = cap_timeout_q;
    res_timeout_d = res_timeout_q;
    abort_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          job_id_d    = job_id;
          num_limbs_d = job_num_limbs;
          // A zero limit would make the solver count down through 65535.
          iter_lim_d  = (job_iter_lim == 16'd0) ? 16'd1 : job_iter_lim;
          cfg_en_d    = 1'b1;
          state_d     = CFG;
        end
      end
      CFG: begin
        limb_cnt_d = '0;
        state_d    = LIMBS;
      end
      LIMBS: begin
        if (limb_valid) begin
          wr_en_d      = 1'b1;
          wr_ind_d     = limb_cnt_q;
          wr_data_re_d = limb_re;
          wr_data_im_d = limb_im;
          limb_cnt_d   = limb_cnt_q + 1'b1;
          if (limb_cnt_q == num_limbs_q) state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
`ifdef SOLVER_FEEDER_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = HOLD;
      end
      HOLD: begin
        // out_ready still shows the previous idle level while start is on the wire.
`ifdef SOLVER_FEEDER_TIMEOUT_EN
        timer_d = timer_q + 32'd1;
`endif
        state_d = RUN;
      end
      RUN: begin
`ifdef SOLVER_FEEDER_TIMEOUT_EN
        timer_d = timer_q + 32'd1;
`endif
        if (out_ready) begin
          cap_count_d = iteration_count;
`ifdef SOLVER_FEEDER_TIMEOUT_EN
          cap_timeout_d = 1'b0;
`endif
          state_d = RESULT;
        end
`ifdef SOLVER_FEEDER_TIMEOUT_EN
        else if (timer_q >= TIMEOUT_LAST) begin
          abort_d       = 1'b1;
          cap_count_d   = 16'hFFFF;
          cap_timeout_d = 1'b1;
          state_d       = RESULT;
        end
`endif
      end
      RESULT: begin
        if (!res_valid_q || res_ready) begin
          res_valid_d = 1'b1;
          res_id_d    = job_id_q;
          res_count_d = cap_count_q;
`ifdef SOLVER_FEEDER_TIMEOUT_EN
          res_timeout_d = cap_timeout_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    job_ready_d  = (state_d == IDLE);
    limb_ready_d = (state_d == LIMBS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      job_ready_q  <= 1'b0;
      limb_ready_q <= 1'b0;
      job_id_q     <= '0;
      limb_cnt_q   <= '0;
      cap_count_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_ind_q     <= '0;
      wr_data_re_q <= '0;
      wr_data_im_q <= '0;
      cfg_en_q     <= 1'b0;
      num_limbs_q  <= '0;
      iter_lim_q   <= '0;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      job_ready_q  <= job_ready_d;
      limb_ready_q <= limb_ready_d;
      job_id_q     <= job_id_d;
      limb_cnt_q   <= limb_cnt_d;
      cap_count_q  <= cap_count_d;
      wr_en_q      <= wr_en_d;
      wr_ind_q     <= wr_ind_d;
      wr_data_re_q <= wr_data_re_d;
      wr_data_im_q <= wr_data_im_d;
      cfg_en_q     <= cfg_en_d;
      num_limbs_q  <= num_limbs_d;
      iter_lim_q   <= iter_lim_d;
      start_q      <= start_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_count_q  <= res_count_d;
    end
  end

`ifdef SOLVER_FEEDER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q       <= '0;
      cap_timeout_q <= 1'b0;
      res_timeout_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      cap_timeout_q <= cap_timeout_d;
      res_timeout_q <= res_timeout_d;
      abort_q       <= abort_d;
    end
  end

  assign res_timeout  = res_timeout_q;
  assign solver_abort = abort_q;
`endif

  assign job_ready       = job_ready_q;
  assign limb_ready      = limb_ready_q;
  assign wr_real_en      = wr_en_q;
  assign wr_imag_en      = wr_en_q;
  assign wr_ind          = wr_ind_q;
  assign wr_data_re      = wr_data_re_q;
  assign wr_data_im      = wr_data_im_q;
  assign wr_num_limbs_en = cfg_en_q;
  assign wr_iter_lim_en  = cfg_en_q;
  assign num_limbs_data  = num_limbs_q;
  assign iter_lim_data   = iter_lim_q;
  assign start           = start_q;
  assign res_valid       = res_valid_q;
  assign res_id          = res_id_q;
  assign res_count       = res_count_q;

endmodule

// File: tb/tb_solver_feeder.sv
// Self-checking bench for solver_feeder: random jobs against a job-level reference and a simple solver model.
`timescale 1ns/1ps
module tb_solver_feeder;
  localparam int LIB = 6;
  localparam int LB  = 32;
  localparam int TO  = 50;

  logic clock = 1'b0;
  logic reset;
  logic job_valid, job_ready;
  logic [15:0] job_id, job_iter_lim;
  logic [LIB-1:0] job_num_limbs;
  logic limb_valid, limb_ready;
  logic [LB-1:0] limb_re, limb_im;
  logic wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start;
  logic [LIB-1:0] wr_ind, num_limbs_data;
  logic [LB-1:0] wr_data_re, wr_data_im;
  logic [15:0] iter_lim_data;
  logic out_ready;
  logic [15:0] iteration_count;
  logic res_valid, res_ready;
  logic [15:0] res_id, res_count;
  logic res_timeout_w, solver_abort_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  solver_feeder #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_num_limbs(job_num_limbs), .job_iter_lim(job_iter_lim),
    .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_re(limb_re), .limb_im(limb_im),
    .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_ind(wr_ind),
    .wr_data_re(wr_data_re), .wr_data_im(wr_data_im),
    .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
    .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
    .start(start), .out_ready(out_ready), .iteration_count(iteration_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count)
`ifdef SOLVER_FEEDER_TIMEOUT_EN
    , .res_timeout(res_timeout_w), .solver_abort(solver_abort_w)
`endif
  );

`ifndef SOLVER_FEEDER_TIMEOUT_EN
  assign res_timeout_w  = 1'b0;
  assign solver_abort_w = 1'b0;
`endif

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Solver model: out_ready drops the cycle after start, returns after sol_lat cycles with sol_count.
  logic [15:0] sol_count;
  int sol_lat;
  bit sol_stuck;
  int sol_left;
  always @(posedge clock) begin
    if (reset) begin
      out_ready <= 1'b1;
      iteration_count <= 16'd0;
      sol_left <= 0;
    end else if (solver_abort_w) begin
      out_ready <= 1'b1;
    end else if (start) begin
      out_ready <= 1'b0;
      iteration_count <= 16'($urandom);
      sol_left <= sol_lat;
    end else if (!out_ready && !sol_stuck) begin
      if (sol_left <= 1) begin
        out_ready <= 1'b1;
        iteration_count <= sol_count;
      end else begin
        sol_left <= sol_left - 1;
      end
    end
  end

  typedef struct {int cyc; bit re_en; bit im_en; logic [LIB-1:0] ind; logic [LB-1:0] re; logic [LB-1:0] im;} wr_t;
  typedef struct {bit n_en; bit l_en; logic [LIB-1:0] n; logic [15:0] lim;} cfg_t;
  wr_t wr_log[$];
  cfg_t cfg_log[$];
  int start_log[$];
  int abort_log[$];
  int overlap = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_real_en || wr_imag_en)
        wr_log.push_back('{cyc, wr_real_en, wr_imag_en, wr_ind, wr_data_re, wr_data_im});
      if (wr_num_limbs_en || wr_iter_lim_en)
        cfg_log.push_back('{wr_num_limbs_en, wr_iter_lim_en, num_limbs_data, iter_lim_data});
      if (start) start_log.push_back(cyc);
      if (solver_abort_w) abort_log.push_back(cyc);
      if (start && (wr_real_en || wr_imag_en)) overlap++;
    end
  end

  logic [LB-1:0] tab_re[64];
  logic [LB-1:0] tab_im[64];

  task automatic clear_logs();
    wr_log.delete(); cfg_log.delete(); start_log.delete(); abort_log.delete(); overlap = 0;
  endtask

  task automatic fill_tables();
    for (int i = 0; i < 64; i++) begin
      tab_re[i] = $urandom;
      tab_im[i] = $urandom;
    end
  endtask

  task automatic send_job(input logic [15:0] id, input logic [LIB-1:0] n, input logic [15:0] lim,
                          input int gmin, input int gmax);
    int budget;
    job_id = id; job_num_limbs = n; job_iter_lim = lim; job_valid = 1'b1;
    budget = 0;
    while (!job_ready && budget < 1000) begin @(posedge clock); #1; budget++; end
    if (!job_ready) begin
      checks++; errors++;
      $display("[TB] FAIL job_accept_timeout: got job_ready=0 expected 1 within 1000 cycles");
      job_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    job_valid = 1'b0;
    for (int i = 0; i <= int'(n); i++) begin
      limb_valid = 1'b0;
      repeat ($urandom_range(gmax, gmin)) begin @(posedge clock); #1; end
      limb_re = tab_re[i]; limb_im = tab_im[i]; limb_valid = 1'b1;
      budget = 0;
      while (!limb_ready && budget < 1000) begin @(posedge clock); #1; budget++; end
      if (!limb_ready) begin
        checks++; errors++;
        $display("[TB] FAIL limb_accept_timeout: got limb_ready=0 expected 1 at beat %0d", i);
        limb_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    limb_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    int b = 0;
    while (!res_valid && b < 2000) begin @(posedge clock); #1; b++; end
    ok = res_valid;
  endtask

  task automatic pop_res();
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b expected 00000",
                         {wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start});
    end
    checks++;
    if ({wr_ind, num_limbs_data, iter_lim_data, wr_data_re, wr_data_im} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got nonzero expected 0");
    end
    checks++;
    if ({job_ready, limb_ready, res_valid, res_id, res_count, res_timeout_w, solver_abort_w} !== '0) begin
      errors++; $display("[TB] FAIL reset_handshake: got job_ready=%b res_valid=%b expected 0", job_ready, res_valid);
    end
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (job_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_job_ready: got %b expected 1", job_ready); end
    checks++;
    if (limb_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_limb_res: got limb_ready=%b res_valid=%b expected 0 0", limb_ready, res_valid);
    end
  endtask

  task automatic test_basic_job();
    bit ok;
    int bad;
    clear_logs(); fill_tables();
    sol_count = 16'd42; sol_lat = 3;
    send_job(16'd7, 6'd2, 16'd100, 0, 0);
    wait_res(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL basic_res_valid: got 0 expected 1"); end
    checks++;
    if (cfg_log.size() != 1 || !cfg_log[0].n_en || !cfg_log[0].l_en || cfg_log[0].n !== 6'd2 || cfg_log[0].lim !== 16'd100) begin
      errors++; $display("[TB] FAIL basic_cfg: got %0d cfg beats expected 1 with N=2 lim=100", cfg_log.size());
    end
    checks++;
    if (wr_log.size() != 3) begin
      errors++; $display("[TB] FAIL basic_wr_count: got %0d expected 3", wr_log.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++)
        if (wr_log[i].ind !== LIB'(i) || wr_log[i].re !== tab_re[i] || wr_log[i].im !== tab_im[i] ||
            !wr_log[i].re_en || !wr_log[i].im_en || wr_log[i].cyc != wr_log[0].cyc + i) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL basic_wr_seq: got %0d bad strobes expected 0", bad); end
      checks++;
      if (start_log.size() != 1 || start_log[0] != wr_log[2].cyc + 1) begin
        errors++; $display("[TB] FAIL basic_start: got %0d pulses expected 1 at cycle %0d", start_log.size(), wr_log[2].cyc + 1);
      end
    end
    checks++;
    if (overlap != 0) begin errors++; $display("[TB] FAIL basic_overlap: got %0d expected 0", overlap); end
    checks++;
    if (res_id !== 16'd7 || res_count !== 16'd42 || res_timeout_w !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_result: got id=%0d count=%0d to=%b expected 7 42 0", res_id, res_count, res_timeout_w);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (res_valid !== 1'b1 || res_id !== 16'd7 || res_count !== 16'd42) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL basic_hold: got %0d unstable cycles expected 0", bad); end
    pop_res();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pop: got res_valid=%b expected 0", res_valid); end
  endtask

  task automatic test_iter_lim_zero();
    bit ok;
    clear_logs(); fill_tables();
    sol_count = 16'd1; sol_lat = 1;
    send_job(16'h0123, 6'd0, 16'd0, 0, 1);
    wait_res(ok);
    checks++;
    if (cfg_log.size() != 1 || !cfg_log[0].l_en || cfg_log[0].lim !== 16'd1 || cfg_log[0].n !== 6'd0) begin
      errors++; $display("[TB] FAIL lim0_cfg: got %0d beats lim=%0d expected 1 beat lim=1",
                         cfg_log.size(), (cfg_log.size() > 0) ? cfg_log[0].lim : 16'hxxxx);
    end
    checks++;
    if (!ok || wr_log.size() != 1 || start_log.size() != 1 || res_id !== 16'h0123) begin
      errors++; $display("[TB] FAIL lim0_job: got %0d writes %0d starts id=%h expected 1 1 0123",
                         wr_log.size(), start_log.size(), res_id);
    end
    pop_res();
  endtask

  task automatic test_limb_gaps();
    bit ok;
    int bad;
    int n;
    clear_logs(); fill_tables();
    n = $urandom_range(7, 3);
    sol_count = 16'($urandom); sol_lat = 4;
    send_job(16'h0A0A, LIB'(n), 16'd500, 2, 2);
    limb_valid = 1'b1;
    wait_res(ok);
    repeat (5) begin @(posedge clock); #1; end
    limb_valid = 1'b0;
    checks++;
    if (!ok || wr_log.size() != n + 1) begin
      errors++; $display("[TB] FAIL gaps_wr_count: got %0d expected %0d", wr_log.size(), n + 1);
    end else begin
      bad = 0;
      for (int i = 0; i <= n; i++) begin
        if (wr_log[i].ind !== LIB'(i) || wr_log[i].re !== tab_re[i] || wr_log[i].im !== tab_im[i]) bad++;
        if (i > 0 && wr_log[i].cyc != wr_log[i-1].cyc + 3) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL gaps_wr_seq: got %0d bad strobes expected 0", bad); end
      checks++;
      if (start_log.size() != 1 || start_log[0] != wr_log[n].cyc + 1) begin
        errors++; $display("[TB] FAIL gaps_start: got %0d pulses expected 1 after last write", start_log.size());
      end
    end
    checks++;
    if (res_count !== sol_count) begin
      errors++; $display("[TB] FAIL gaps_count: got %0d expected %0d", res_count, sol_count);
    end
    pop_res();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] ca, cb;
    clear_logs(); fill_tables();
    ca = 16'($urandom); cb = ca ^ 16'h8000;
    sol_count = ca; sol_lat = 2;
    send_job(16'h1111, 6'd1, 16'd20, 0, 1);
    wait_res(ok);
    checks++;
    if (!ok || res_id !== 16'h1111 || res_count !== ca) begin
      errors++; $display("[TB] FAIL b2b_first: got id=%h count=%h expected 1111 %h", res_id, res_count, ca);
    end
    sol_count = cb;
    send_job(16'h2222, 6'd2, 16'd30, 0, 1);
    repeat (20) begin @(posedge clock); #1; end
    checks++;
    if (job_ready !== 1'b0 || res_id !== 16'h1111 || res_count !== ca || res_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_stall: got job_ready=%b id=%h expected 0 1111", job_ready, res_id);
    end
    pop_res();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 16'h2222 || res_count !== cb) begin
      errors++; $display("[TB] FAIL b2b_second: got v=%b id=%h count=%h expected 1 2222 %h", res_valid, res_id, res_count, cb);
    end
    pop_res();
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_drain: got res_valid=%b job_ready=%b expected 0 1", res_valid, job_ready);
    end
  endtask

  task automatic test_random_jobs();
    bit ok;
    int bad;
    int n;
    logic [15:0] id, lim, explim;
    for (int j = 0; j < 8; j++) begin
      clear_logs(); fill_tables();
      n = $urandom_range(9, 0);
      id = 16'($urandom);
      lim = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom);
      explim = (lim == 16'd0) ? 16'd1 : lim;
      sol_count = 16'($urandom); sol_lat = $urandom_range(10, 1);
      send_job(id, LIB'(n), lim, 0, 3);
      wait_res(ok);
      bad = 0;
      if (!ok || res_id !== id || res_count !== sol_count || res_timeout_w !== 1'b0) bad++;
      if (cfg_log.size() != 1 || cfg_log[0].n !== LIB'(n) || cfg_log[0].lim !== explim) bad++;
      if (wr_log.size() != n + 1 || start_log.size() != 1 || overlap != 0) bad++;
      else begin
        for (int i = 0; i <= n; i++)
          if (wr_log[i].ind !== LIB'(i) || wr_log[i].re !== tab_re[i] || wr_log[i].im !== tab_im[i]) bad++;
        if (start_log[0] != wr_log[n].cyc + 1) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("[TB] FAIL random_job_%0d: got %0d discrepancies (id=%h count=%h) expected 0 (id=%h count=%h)",
                           j, bad, res_id, res_count, id, sol_count);
      end
      repeat ($urandom_range(3, 0)) begin @(posedge clock); #1; end
      pop_res();
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int budget;
    clear_logs(); fill_tables();
    sol_count = 16'd77; sol_lat = 2;
    send_job(16'hAAAA, 6'd0, 16'd5, 0, 0);
    wait_res(ok);
    job_id = 16'hBBBB; job_num_limbs = 6'd8; job_iter_lim = 16'd9; job_valid = 1'b1;
    budget = 0;
    while (!job_ready && budget < 100) begin @(posedge clock); #1; budget++; end
    @(posedge clock); #1;
    job_valid = 1'b0;
    limb_valid = 1'b1; limb_re = 32'h5; limb_im = 32'h6;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    clear_logs();
    reset = 1'b0;
    repeat (20) begin @(posedge clock); #1; end
    limb_valid = 1'b0;
    checks++;
    if (wr_log.size() != 0 || start_log.size() != 0 || cfg_log.size() != 0) begin
      errors++; $display("[TB] FAIL midreset_quiet: got %0d writes %0d starts %0d cfgs expected 0",
                         wr_log.size(), start_log.size(), cfg_log.size());
    end
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1 || limb_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_state: got res_valid=%b job_ready=%b limb_ready=%b expected 0 1 0",
                         res_valid, job_ready, limb_ready);
    end
  endtask

`ifdef SOLVER_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    clear_logs(); fill_tables();
    sol_stuck = 1'b1; sol_lat = 1;
    send_job(16'h0BAD, 6'd1, 16'd9, 0, 0);
    wait_res(ok);
    checks++;
    if (!ok || abort_log.size() != 1 || start_log.size() != 1 || abort_log[0] != start_log[0] + TO) begin
      errors++; $display("[TB] FAIL timeout_abort: got %0d abort pulses expected 1 at start+%0d", abort_log.size(), TO);
    end
    checks++;
    if (res_count !== 16'hFFFF || res_timeout_w !== 1'b1 || res_id !== 16'h0BAD) begin
      errors++; $display("[TB] FAIL timeout_result: got count=%h to=%b id=%h expected ffff 1 0bad",
                         res_count, res_timeout_w, res_id);
    end
    pop_res();
    sol_stuck = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL global_watchdog: got no finish expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    job_valid = 1'b0; job_id = '0; job_num_limbs = '0; job_iter_lim = '0;
    limb_valid = 1'b0; limb_re = '0; limb_im = '0; res_ready = 1'b0;
    sol_count = '0; sol_lat = 2; sol_stuck = 1'b0;
    test_reset();
    test_basic_job();
    test_iter_lim_zero();
    test_limb_gaps();
    test_back_to_back();
    test_random_jobs();
`ifdef SOLVER_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
